// File: rtl/generic_fifo_pkg.sv
// generic_fifo_pkg
// Shared helpers for the single-clock FWFT FIFO envelope:
//   BYTE_WIDTH  - bits covered by one parity bit
//   parWidth()  - number of parity bits for a given data width (PAR_WIDTH)
//   ptrInc()    - pointer increment modulo the FIFO depth (non-power-of-2 safe)
//   byteParity()- even parity bit of one byte
// Optional feature macro used by the files importing this package:
//   GENERIC_FIFO_PARITY_EN
package generic_fifo_pkg;

  localparam int BYTE_WIDTH = 8;

  function automatic int parWidth(input int datWidth);
    return datWidth / BYTE_WIDTH;
  endfunction

  // Wraps numEntries-1 back to 0 so the depth need not be a power of two.
  function automatic int ptrInc(input int ptr, input int numEntries);
    return (ptr >= numEntries - 1) ? 0 : ptr + 1;
  endfunction

  // Even parity: the stored bit makes the byte plus parity bit an even count of ones.
  function automatic logic byteParity(input logic [BYTE_WIDTH-1:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/generic_fifo_fwft_stage.sv
// generic_fifo_fwft_stage
// Two-entry output buffer (head + skid) behind a 1-cycle-latency RAM read port.
// Tracks the in-flight read, decides when to issue the next RAM read, and
// (with GENERIC_FIFO_PARITY_EN) checks per-byte parity as words leave the RAM.
// Ports:
//   clk, reset_n      clock, async active-low reset
//   flush_i           synchronous clear, drops buffered and in-flight words
//   rdOp_i            pop request from the user
//   ramNotEmpty_i     RAM holds at least one unread word
//   ramRdata_i        RAM read data (data plus parity bits when enabled)
//   ramRdEn_o         issue a RAM read this cycle
//   popAcc_o          pop accepted this cycle
//   rdData_o          head word
//   rdValid_o         head word present
//   rdParityErr_o     head word failed its parity check
module generic_fifo_fwft_stage
  import generic_fifo_pkg::*;
#(
  parameter int DAT_WIDTH = 96,
  parameter int RAM_WIDTH = 96
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 flush_i,
  input  logic                 rdOp_i,
  input  logic                 ramNotEmpty_i,
  input  logic [RAM_WIDTH-1:0] ramRdata_i,
  output logic                 ramRdEn_o,
  output logic                 popAcc_o,
  output logic [DAT_WIDTH-1:0] rdData_o,
  output logic                 rdValid_o,
  output logic                 rdParityErr_o
);

  logic [DAT_WIDTH-1:0] head_q, head_d, skid_q, skid_d;
  logic                 headErr_q, headErr_d, skidErr_q, skidErr_d;
  logic [1:0]           bufCount_q, bufCount_d;
  logic                 inflight_q, inflight_d;
  logic [1:0]           cntAfterPop;
  logic [DAT_WIDTH-1:0] inData;
  logic                 inErr;
  logic                 popAcc, issue;

  assign inData = ramRdata_i[DAT_WIDTH-1:0];

`ifdef GENERIC_FIFO_PARITY_EN
  localparam int PAR_WIDTH = parWidth(DAT_WIDTH);

  // Any byte whose stored parity disagrees with its recomputed parity flags the word.
  always_comb begin
    inErr = 1'b0;
    for (int b = 0; b < PAR_WIDTH; b++) begin
      inErr = inErr | (byteParity(ramRdata_i[b*BYTE_WIDTH +: BYTE_WIDTH]) ^ ramRdata_i[DAT_WIDTH+b]);
    end
  end
`else
  assign inErr = 1'b0;
`endif

  // Issue looks at occupancy after this cycle's pop so a pop every cycle never starves.
  always_comb begin
    popAcc      = rdOp_i && (bufCount_q != 2'd0) && !flush_i;
    cntAfterPop = bufCount_q - {1'b0, popAcc};
    issue       = ramNotEmpty_i && !flush_i && ((cntAfterPop + {1'b0, inflight_q}) < 2'd2);

    head_d     = head_q;
    skid_d     = skid_q;
    headErr_d  = headErr_q;
    skidErr_d  = skidErr_q;
    if (popAcc) begin
      head_d    = skid_q;
      headErr_d = skidErr_q;
    end
    // The returning RAM word lands in the first free slot after the pop.
    if (inflight_q) begin
      if (cntAfterPop == 2'd0) begin
        head_d    = inData;
        headErr_d = inErr;
      end else begin
        skid_d    = inData;
        skidErr_d = inErr;
      end
    end
    bufCount_d = cntAfterPop + {1'b0, inflight_q};
    inflight_d = issue;
  end

  // Flush clears everything, including a read already on its way back from the RAM.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q     <= '0;
      skid_q     <= '0;
      headErr_q  <= 1'b0;
      skidErr_q  <= 1'b0;
      bufCount_q <= 2'd0;
      inflight_q <= 1'b0;
    end else if (flush_i) begin
      head_q     <= '0;
      skid_q     <= '0;
      headErr_q  <= 1'b0;
      skidErr_q  <= 1'b0;
      bufCount_q <= 2'd0;
      inflight_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      skid_q     <= skid_d;
      headErr_q  <= headErr_d;
      skidErr_q  <= skidErr_d;
      bufCount_q <= bufCount_d;
      inflight_q <= inflight_d;
    end
  end

  assign ramRdEn_o     = issue;
  assign popAcc_o      = popAcc;
  assign rdData_o      = head_q;
  assign rdValid_o     = (bufCount_q != 2'd0);
  assign rdParityErr_o = rdValid_o && headErr_q;

endmodule

// File: rtl/generic_1clk_fwft_fifo_env.sv
// generic_fifo_ram_1r1w
// Behavioural stand-in for the CRF2PA-class 1r1w compiled RAM: bit-masked
// synchronous write, registered synchronous read (1-cycle latency).
// Contents are never reset; only the read register is.
module generic_fifo_ram_1r1w #(
  parameter int WIDTH             = 96,
  parameter int ADDR_WIDTH        = 4,
  parameter int RAM_CTRL_VEC_SIZE = 7
) (
  input  logic                         clk,
  input  logic                         sreset_n,
  input  logic                         scanMode_i,
  input  logic                         ramBistMode_i,
  input  logic [RAM_CTRL_VEC_SIZE-1:0] ramCtrlVec_i,
  input  logic                         wrEn_i,
  input  logic [ADDR_WIDTH-1:0]        wrAddr_i,
  input  logic [WIDTH-1:0]             wrData_i,
  input  logic [WIDTH-1:0]             wrMask_i,
  input  logic                         rdEn_i,
  input  logic [ADDR_WIDTH-1:0]        rdAddr_i,
  output logic [WIDTH-1:0]             rdData_o
);

  logic [WIDTH-1:0] mem_q [2**ADDR_WIDTH];
  logic [WIDTH-1:0] rdData_q;
  logic             unusedCtrl;

  // Test and tuning controls only matter to the real macro.
  assign unusedCtrl = ^{scanMode_i, ramBistMode_i, ramCtrlVec_i};

  // Mask bit 0 keeps the bit already stored in the slot.
  always_ff @(posedge clk) begin
    if (wrEn_i) begin
      mem_q[wrAddr_i] <= (mem_q[wrAddr_i] & ~wrMask_i) | (wrData_i & wrMask_i);
    end
  end

  always_ff @(posedge clk or negedge sreset_n) begin
    if (!sreset_n) begin
      rdData_q <= '0;
    end else if (rdEn_i) begin
      rdData_q <= mem_q[rdAddr_i];
    end
  end

  assign rdData_o = rdData_q;

endmodule

// generic_1clk_fwft_fifo_env
// Single-clock FWFT FIFO around a 1r1w synchronous-read RAM. Supports any depth
// from 2 to 2^PTR_WIDTH, programmable almost-full/empty thresholds, synchronous
// flush, and optional per-byte even parity (macro GENERIC_FIFO_PARITY_EN).
// Ports:
//   clk, reset_n          clock, async active-low reset
//   flush                 synchronous clear of all state (RAM contents kept)
//   wr_op/wr_data/wr_mask push request, data, per-bit write enable
//   rd_op                 pop the head word
//   rd_data/rd_valid      head word and its presence
//   full/empty/almost_*   registered occupancy flags
//   entry_used            accepted, not-yet-popped words
//   wr_full_err           pulse: push dropped because full
//   rd_empty_err          pulse: pop dropped because no head word
//   rd_parity_err         head word parity error (0 without parity)
//   scan_mode/ram_ctrl_vec passed to the RAM
module generic_1clk_fwft_fifo_env
  import generic_fifo_pkg::*;
#(
  parameter int DAT_WIDTH         = 96,
  parameter int NUM_OF_ENTRIES    = 16,
  parameter int PTR_WIDTH         = 4,
  parameter int AFULL_TH          = 12,
  parameter int AEMPTY_TH         = 2,
  parameter int RAM_CTRL_VEC_SIZE = 7
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         flush,
  input  logic                         wr_op,
  input  logic [DAT_WIDTH-1:0]         wr_data,
  input  logic [DAT_WIDTH-1:0]         wr_mask,
  input  logic                         rd_op,
  output logic [DAT_WIDTH-1:0]         rd_data,
  output logic                         rd_valid,
  output logic                         full,
  output logic                         empty,
  output logic                         almost_full,
  output logic                         almost_empty,
  output logic [PTR_WIDTH:0]           entry_used,
  output logic                         wr_full_err,
  output logic                         rd_empty_err,
  output logic                         rd_parity_err,
  input  logic                         scan_mode,
  input  logic [RAM_CTRL_VEC_SIZE-1:0] ram_ctrl_vec
);

  localparam int CW = PTR_WIDTH + 1;
`ifdef GENERIC_FIFO_PARITY_EN
  localparam int PAR_WIDTH = parWidth(DAT_WIDTH);
  localparam int RAM_WIDTH = DAT_WIDTH + PAR_WIDTH;
`else
  localparam int RAM_WIDTH = DAT_WIDTH;
`endif

  logic [PTR_WIDTH-1:0] wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [CW-1:0]        ramOcc_q, ramOcc_d, entryUsed_q, entryUsed_d;
  logic                 full_q, full_d, empty_q, empty_d;
  logic                 aFull_q, aFull_d, aEmpty_q, aEmpty_d;
  logic                 wrFullErr_q, wrFullErr_d, rdEmptyErr_q, rdEmptyErr_d;
  logic                 pushAcc, popAcc, ramRdEn, stageValid;
  logic [RAM_WIDTH-1:0] ramWdata, ramWmask, ramRdata;

`ifdef GENERIC_FIFO_PARITY_EN
  logic [PAR_WIDTH-1:0] wrParity;
  logic                 unusedWrMask;

  // Parity covers the whole word, so partial writes are not possible here.
  always_comb begin
    wrParity = '0;
    for (int b = 0; b < PAR_WIDTH; b++) begin
      wrParity[b] = byteParity(wr_data[b*BYTE_WIDTH +: BYTE_WIDTH]);
    end
  end
  assign ramWdata     = {wrParity, wr_data};
  assign ramWmask     = '1;
  assign unusedWrMask = ^wr_mask;
`else
  assign ramWdata = wr_data;
  assign ramWmask = wr_mask;
`endif

  // Push sees only the registered full, so a same-cycle pop never frees room for it.
  always_comb begin
    pushAcc      = wr_op && !full_q && !flush;
    wrFullErr_d  = wr_op && full_q && !flush;
    rdEmptyErr_d = rd_op && !stageValid && !flush;
    wrPtr_d      = pushAcc ? PTR_WIDTH'(ptrInc(int'(wrPtr_q), NUM_OF_ENTRIES)) : wrPtr_q;
    rdPtr_d      = ramRdEn ? PTR_WIDTH'(ptrInc(int'(rdPtr_q), NUM_OF_ENTRIES)) : rdPtr_q;
    ramOcc_d     = ramOcc_q + CW'(pushAcc) - CW'(ramRdEn);
    entryUsed_d  = entryUsed_q + CW'(pushAcc) - CW'(popAcc);
    full_d       = (int'(entryUsed_d) == NUM_OF_ENTRIES);
    empty_d      = (entryUsed_d == '0);
    aFull_d      = (int'(entryUsed_d) >= AFULL_TH);
    aEmpty_d     = (int'(entryUsed_d) <= AEMPTY_TH);
  end

  // Pointers, counts and flags; flush returns them to their reset values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wrPtr_q      <= '0;
      rdPtr_q      <= '0;
      ramOcc_q     <= '0;
      entryUsed_q  <= '0;
      full_q       <= 1'b0;
      empty_q      <= 1'b1;
      aFull_q      <= 1'b0;
      aEmpty_q     <= 1'b1;
      wrFullErr_q  <= 1'b0;
      rdEmptyErr_q <= 1'b0;
    end else if (flush) begin
      wrPtr_q      <= '0;
      rdPtr_q      <= '0;
      ramOcc_q     <= '0;
      entryUsed_q  <= '0;
      full_q       <= 1'b0;
      empty_q      <= 1'b1;
      aFull_q      <= 1'b0;
      aEmpty_q     <= 1'b1;
      wrFullErr_q  <= 1'b0;
      rdEmptyErr_q <= 1'b0;
    end else begin
      wrPtr_q      <= wrPtr_d;
      rdPtr_q      <= rdPtr_d;
      ramOcc_q     <= ramOcc_d;
      entryUsed_q  <= entryUsed_d;
      full_q       <= full_d;
      empty_q      <= empty_d;
      aFull_q      <= aFull_d;
      aEmpty_q     <= aEmpty_d;
      wrFullErr_q  <= wrFullErr_d;
      rdEmptyErr_q <= rdEmptyErr_d;
    end
  end

  generic_fifo_ram_1r1w #(
    .WIDTH             (RAM_WIDTH),
    .ADDR_WIDTH        (PTR_WIDTH),
    .RAM_CTRL_VEC_SIZE (RAM_CTRL_VEC_SIZE)
  ) u_ram (
    .clk           (clk),
    .sreset_n      (reset_n),
    .scanMode_i    (scan_mode),
    .ramBistMode_i (1'b0),
    .ramCtrlVec_i  (ram_ctrl_vec),
    .wrEn_i        (pushAcc),
    .wrAddr_i      (wrPtr_q),
    .wrData_i      (ramWdata),
    .wrMask_i      (ramWmask),
    .rdEn_i        (ramRdEn),
    .rdAddr_i      (rdPtr_q),
    .rdData_o      (ramRdata)
  );

  generic_fifo_fwft_stage #(
    .DAT_WIDTH (DAT_WIDTH),
    .RAM_WIDTH (RAM_WIDTH)
  ) u_stage (
    .clk           (clk),
    .reset_n       (reset_n),
    .flush_i       (flush),
    .rdOp_i        (rd_op),
    .ramNotEmpty_i (ramOcc_q != '0),
    .ramRdata_i    (ramRdata),
    .ramRdEn_o     (ramRdEn),
    .popAcc_o      (popAcc),
    .rdData_o      (rd_data),
    .rdValid_o     (stageValid),
    .rdParityErr_o (rd_parity_err)
  );

  assign rd_valid     = stageValid;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = aFull_q;
  assign almost_empty = aEmpty_q;
  assign entry_used   = entryUsed_q;
  assign wr_full_err  = wrFullErr_q;
  assign rd_empty_err = rdEmptyErr_q;

endmodule

// File: tb/tb_generic_1clk_fwft_fifo_env.sv
// tb_generic_1clk_fwft_fifo_env
// Self-checking bench: a table of single-cycle vectors with hand-computed flag
// expectations, a data scoreboard filled on accepted pushes and drained on pops,
// and hand-written sequences for latency, fill/overflow, drain, steady state,
// flush and masked-write/parity corner cases. Depth 12 exercises a
// non-power-of-2 pointer wrap.
module tb_generic_1clk_fwft_fifo_env;

  localparam int DW  = 96;
  localparam int N   = 12;
  localparam int PW  = 4;
  localparam int CW  = PW + 1;
  localparam int RCV = 7;
  localparam logic [DW-1:0] ONES = '1;

  logic           clk = 1'b0;
  logic           reset_n, flush, wr_op, rd_op, scan_mode;
  logic [DW-1:0]  wr_data, wr_mask, rd_data;
  logic           rd_valid, full, empty, almost_full, almost_empty;
  logic [CW-1:0]  entry_used;
  logic           wr_full_err, rd_empty_err, rd_parity_err;
  logic [RCV-1:0] ram_ctrl_vec;

  int checks   = 0;
  int failures = 0;
  int popCount = 0;
  logic [DW-1:0] sbQ[$];

  typedef struct {
    logic          wr, rd, fl;
    logic [7:0]    tag;
    logic [CW-1:0] used;
    logic          empty, full, ae, af, werr, rerr;
  } vec_t;
  vec_t vecs[11];

  always #5 clk = ~clk;

  generic_1clk_fwft_fifo_env #(
    .DAT_WIDTH(DW), .NUM_OF_ENTRIES(N), .PTR_WIDTH(PW),
    .AFULL_TH(12), .AEMPTY_TH(2), .RAM_CTRL_VEC_SIZE(RCV)
  ) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush), .wr_op(wr_op), .wr_data(wr_data),
    .wr_mask(wr_mask), .rd_op(rd_op), .rd_data(rd_data), .rd_valid(rd_valid),
    .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .entry_used(entry_used), .wr_full_err(wr_full_err), .rd_empty_err(rd_empty_err),
    .rd_parity_err(rd_parity_err), .scan_mode(scan_mode), .ram_ctrl_vec(ram_ctrl_vec)
  );

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic checkFlag(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic checkCount(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock: sample the head mid-cycle, drive inputs, wait past the edge.
  task automatic applyStimulus(input logic wr, input logic rd, input logic fl,
                               input logic [DW-1:0] data, input logic [DW-1:0] mask,
                               input logic [DW-1:0] expWord);
    logic pushOk;
    @(negedge clk);
    pushOk = wr && !fl && (sbQ.size() < N);
    if (rd && !fl && rd_valid) begin
      popCount++;
      if (sbQ.size() == 0) checkCount("sb_underflow", 1, 0);
      else checkOutput("rd_data", rd_data, sbQ.pop_front());
    end
    if (fl) sbQ.delete();
    else if (pushOk) sbQ.push_back(expWord);
    wr_op   = wr;
    rd_op   = rd;
    flush   = fl;
    wr_data = data;
    wr_mask = mask;
    @(posedge clk);
    #1;
    wr_op = 1'b0;
    rd_op = 1'b0;
    flush = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, 1'b0, '0, ONES, '0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [DW-1:0] w;
    int errSeen;

    // wr, rd, fl, tag, used, empty, full, ae, af, werr, rerr
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'h10, 5'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 8'h11, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 8'h12, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 8'h00, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 8'h13, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 8'h00, 5'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 8'h00, 5'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 8'h00, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 8'h00, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 8'h14, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 8'h00, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    reset_n = 1'b0; flush = 1'b0; wr_op = 1'b0; rd_op = 1'b0;
    wr_data = '0; wr_mask = ONES; scan_mode = 1'b0; ram_ctrl_vec = '0;
    #12;
    checkFlag("rst_empty", empty, 1'b1);
    checkFlag("rst_aempty", almost_empty, 1'b1);
    checkFlag("rst_full", full, 1'b0);
    checkFlag("rst_afull", almost_full, 1'b0);
    checkFlag("rst_valid", rd_valid, 1'b0);
    checkCount("rst_used", int'(entry_used), 0);
    checkOutput("rst_rd_data", rd_data, '0);
    checkFlag("rst_errs", wr_full_err | rd_empty_err | rd_parity_err, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;

    // First-word latency: visible two edges after the push edge.
    w = {12{8'hA5}};
    applyStimulus(1'b1, 1'b0, 1'b0, w, ONES, w);
    checkFlag("lat_e0_empty", empty, 1'b0);
    checkFlag("lat_e0_valid", rd_valid, 1'b0);
    checkCount("lat_e0_used", int'(entry_used), 1);
    idle(1);
    checkFlag("lat_e1_valid", rd_valid, 1'b0);
    idle(1);
    checkFlag("lat_e2_valid", rd_valid, 1'b1);
    checkOutput("lat_e2_data", rd_data, w);
    checkFlag("lat_e2_perr", rd_parity_err, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, '0, ONES, '0);
    checkFlag("lat_pop_empty", empty, 1'b1);

    for (int i = 0; i < 11; i++) begin
      w = {12{vecs[i].tag}};
      applyStimulus(vecs[i].wr, vecs[i].rd, vecs[i].fl, w, ONES, w);
      checkCount($sformatf("v%0d_used", i), int'(entry_used), int'(vecs[i].used));
      checkFlag($sformatf("v%0d_empty", i), empty, vecs[i].empty);
      checkFlag($sformatf("v%0d_full", i), full, vecs[i].full);
      checkFlag($sformatf("v%0d_aempty", i), almost_empty, vecs[i].ae);
      checkFlag($sformatf("v%0d_afull", i), almost_full, vecs[i].af);
      checkFlag($sformatf("v%0d_wrerr", i), wr_full_err, vecs[i].werr);
      checkFlag($sformatf("v%0d_rderr", i), rd_empty_err, vecs[i].rerr);
    end
    checkCount("table_sb_empty", sbQ.size(), 0);

    // Fill to capacity, then overflow by one.
    for (int i = 0; i < N; i++) begin
      w = {3{32'hC0DE_0000 + 32'(i)}};
      applyStimulus(1'b1, 1'b0, 1'b0, w, ONES, w);
      if (i == N - 2) checkFlag("fill11_afull", almost_full, 1'b0);
    end
    checkFlag("fill_full", full, 1'b1);
    checkFlag("fill_afull", almost_full, 1'b1);
    checkCount("fill_used", int'(entry_used), N);
    applyStimulus(1'b1, 1'b0, 1'b0, {3{32'hDEAD_BEEF}}, ONES, '0);
    checkFlag("ovf_wrerr", wr_full_err, 1'b1);
    checkCount("ovf_used", int'(entry_used), N);
    idle(1);
    checkFlag("ovf_wrerr_pulse", wr_full_err, 1'b0);

    // Back-to-back drain with wrap.
    popCount = 0;
    for (int i = 0; i < N; i++) applyStimulus(1'b0, 1'b1, 1'b0, '0, ONES, '0);
    checkCount("drain_pops", popCount, N);
    checkFlag("drain_empty", empty, 1'b1);
    checkFlag("drain_rderr", rd_empty_err, 1'b0);

    // Steady state at 5 entries with simultaneous push/pop.
    for (int i = 0; i < 5; i++) begin
      w = {3{32'h5000_0000 + 32'(i)}};
      applyStimulus(1'b1, 1'b0, 1'b0, w, ONES, w);
    end
    idle(2);
    popCount = 0;
    errSeen  = 0;
    for (int i = 0; i < 20; i++) begin
      w = {3{32'h6000_0000 + 32'(i)}};
      applyStimulus(1'b1, 1'b1, 1'b0, w, ONES, w);
      checkCount($sformatf("steady%0d_used", i), int'(entry_used), 5);
      errSeen += int'(wr_full_err) + int'(rd_empty_err);
    end
    checkCount("steady_pops", popCount, 20);
    checkCount("steady_errs", errSeen, 0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 1'b0, '0, ONES, '0);
    checkFlag("steady_empty", empty, 1'b1);
    checkCount("steady_sb", sbQ.size(), 0);

    // Pop on empty pulses the error for exactly one cycle.
    applyStimulus(1'b0, 1'b1, 1'b0, '0, ONES, '0);
    checkFlag("emptyrd_err", rd_empty_err, 1'b1);
    idle(1);
    checkFlag("emptyrd_pulse", rd_empty_err, 1'b0);

    // Flush with buffered words and a read in flight.
    for (int i = 0; i < 3; i++) begin
      w = {3{32'h7000_0000 + 32'(i)}};
      applyStimulus(1'b1, 1'b0, 1'b0, w, ONES, w);
    end
    applyStimulus(1'b1, 1'b1, 1'b1, {3{32'h7777_7777}}, ONES, '0);
    checkFlag("flush_empty", empty, 1'b1);
    checkFlag("flush_valid", rd_valid, 1'b0);
    checkCount("flush_used", int'(entry_used), 0);
    checkFlag("flush_aempty", almost_empty, 1'b1);
    checkFlag("flush_errs", wr_full_err | rd_empty_err, 1'b0);
    idle(3);
    checkFlag("flush_nostale", rd_valid, 1'b0);

`ifdef GENERIC_FIFO_PARITY_EN
    // Corrupt a stored bit of slot 0 between write and read.
    w = {12{8'h3C}};
    applyStimulus(1'b1, 1'b0, 1'b0, w, '0, w ^ (ONES & {{(DW-6){1'b0}}, 6'b100000}));
    dut.u_ram.mem_q[0][5] = ~dut.u_ram.mem_q[0][5];
    idle(2);
    checkFlag("par_valid", rd_valid, 1'b1);
    checkFlag("par_err", rd_parity_err, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, '0, ONES, '0);
    checkFlag("par_err_clr", rd_parity_err, 1'b0);
`else
    // Slot 0 first gets all ones, then a partial write of the low byte only.
    applyStimulus(1'b1, 1'b0, 1'b0, ONES, ONES, ONES);
    idle(2);
    applyStimulus(1'b0, 1'b1, 1'b0, '0, ONES, '0);
    applyStimulus(1'b0, 1'b0, 1'b1, '0, ONES, '0);
    w = {{(DW-8){1'b1}}, 8'h00};
    applyStimulus(1'b1, 1'b0, 1'b0, '0, {{(DW-8){1'b0}}, 8'hFF}, w);
    idle(2);
    checkFlag("mask_valid", rd_valid, 1'b1);
    checkOutput("mask_head", rd_data, w);
    checkFlag("mask_perr", rd_parity_err, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, '0, ONES, '0);
`endif
    checkFlag("final_empty", empty, 1'b1);
    checkCount("final_sb", sbQ.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
